// File: rtl/dbi_pkg.sv
// -----------------------------------------------------------------------------
// dbi_pkg
// Shared definitions for the DBI-DC transmit encoder and receive decoder.
//   DBI_DATA_W     default data word width
//   DBI_THRESHOLD  most zeros a legal wire word may carry (DBI_DATA_W/2)
//   DBI_MAX_W      widest word count_zeros can inspect
//   occ_e          occupancy states of the 2-entry stream buffer
//   count_zeros()  number of zero bits in the low 'width' bits of a word
// -----------------------------------------------------------------------------
package dbi_pkg;

  localparam int unsigned DBI_DATA_W    = 8;
  localparam int unsigned DBI_THRESHOLD = DBI_DATA_W / 2;
  localparam int unsigned DBI_MAX_W     = 64;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bits above 'width' are ignored so callers can zero-extend narrower words.
  function automatic int unsigned count_zeros(input logic [DBI_MAX_W-1:0] word,
                                              input int unsigned width);
    int unsigned zeros;
    zeros = 0;
    for (int unsigned i = 0; i < DBI_MAX_W; i++) begin
      if (i < width && !word[i]) zeros++;
    end
    return zeros;
  endfunction

endpackage

// File: rtl/dbi_skid_buf.sv
// -----------------------------------------------------------------------------
// dbi_skid_buf
// Generic 2-entry in-order valid/ready buffer. A single entry sustains full
// throughput; the second entry absorbs one word of downstream backpressure
// so that in_ready can be a register.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake (in_ready registered)
//   in_data [WIDTH]        word to store
//   out_valid/out_ready    downstream handshake
//   out_data [WIDTH]       head entry (registered)
// -----------------------------------------------------------------------------
module dbi_skid_buf
  import dbi_pkg::*;
#(
  parameter int unsigned WIDTH = DBI_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  occ_e             state;
  occ_e             state_next;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push     = in_valid & ready_q;
  assign pop      = out_valid & out_ready;
  assign in_ready = ready_q;
  assign out_data = head;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OCC_EMPTY;
    else        state <= state_next;
  end

  // Occupancy transitions; FULL never sees a push because in_ready is low.
  always_comb begin
    state_next = state;
    case (state)
      OCC_EMPTY: if (push) state_next = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_next = OCC_FULL;
        else if (!push && pop) state_next = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) state_next = OCC_ONE;
      default:   state_next = OCC_EMPTY;
    endcase
  end

  // Output decode of the occupancy state.
  always_comb begin
    out_valid = (state != OCC_EMPTY);
  end

  // in_ready is looked ahead from the next occupancy so it can be registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b1;
    else        ready_q <= (state_next != OCC_FULL);
  end

  // Entry storage: head is what downstream sees, tail is the overflow slot.
  // Head only changes on a push into an empty/draining buffer or on a pop,
  // so it stays stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        OCC_EMPTY: if (push) head <= in_data;
        OCC_ONE: begin
          if (push && pop) head <= in_data;
          else if (push)   tail <= in_data;
        end
        OCC_FULL:  if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dbi_decoder.sv
// -----------------------------------------------------------------------------
// dbi_decoder
// Receive side of the DBI-DC link: undoes the data inversion, forwards the
// restored word through a 2-entry valid/ready buffer, and monitors the link.
// DATA_W must be even, >= 2 and no wider than DBI_MAX_W.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_data [DATA_W]      wire data as received
//   in_dbi                1 = wire data was inverted by the transmitter
//   out_valid/out_ready   downstream handshake
//   out_data [DATA_W]     decoded data (registered)
//   err                   sticky: an accepted wire word had too many zeros
//   inv_cnt [CNT_W]       saturating count of accepted inverted words
//   clr                   synchronous clear of err and inv_cnt
// -----------------------------------------------------------------------------
module dbi_decoder
  import dbi_pkg::*;
#(
  parameter int unsigned DATA_W = DBI_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dbi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err,
  output logic [CNT_W-1:0]  inv_cnt,
  input  logic              clr
);

  localparam int unsigned THRESHOLD = DATA_W / 2;

  logic [DATA_W-1:0] decoded;
  logic              accept;
  logic              violation;

  // The buffer stores already-decoded words.
  assign decoded = in_dbi ? ~in_data : in_data;
  assign accept  = in_valid & in_ready;

  // DBI-DC guarantees at most half the wire bits are zero, whatever in_dbi says.
  assign violation = accept &&
                     (count_zeros(DBI_MAX_W'(in_data), DATA_W) > THRESHOLD);

  dbi_skid_buf #(
    .WIDTH(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (decoded),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Sticky error: a violation in the same cycle as clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (violation) err <= 1'b1;
    else if (clr)       err <= 1'b0;
  end

  // Inverted-word counter: clr beats a simultaneous increment, saturates high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      inv_cnt <= '0;
    else if (clr)
      inv_cnt <= '0;
    else if (accept && in_dbi && (inv_cnt != {CNT_W{1'b1}}))
      inv_cnt <= inv_cnt + 1'b1;
  end

endmodule

// File: tb/tb_dbi_decoder.sv
// -----------------------------------------------------------------------------
// tb_dbi_decoder
// Self-checking bench for dbi_decoder (DATA_W=8, CNT_W=4).
// -----------------------------------------------------------------------------
module tb_dbi_decoder;
  import dbi_pkg::*;

  localparam int DW      = DBI_DATA_W;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_dbi;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          err;
  logic [CW-1:0] inv_cnt;
  logic          clr;

  int compared;
  int mismatched;

  // Reference model: queue of decoded words plus monitor state.
  logic [DW-1:0] mq[$];
  logic          m_err;
  int            m_cnt;
  int            m_accepted;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          dbi;
    logic          ordy;
    logic          c;
    logic          ev;
    logic [DW-1:0] ed;
    logic          er;
    logic          ee;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t vecs[9];

  dbi_decoder #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dbi   (in_dbi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err      (err),
    .inv_cnt  (inv_cnt),
    .clr      (clr)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetModel();
    mq.delete();
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and leave
  // the bench 1 ns after that edge for sampling.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d,
                               input logic dbi, input logic ordy, input logic c);
    logic acc;
    logic del;
    int   zeros;
    in_valid  = iv;
    in_data   = d;
    in_dbi    = dbi;
    out_ready = ordy;
    clr       = c;
    acc   = iv && (mq.size() < 2);
    del   = ordy && (mq.size() > 0);
    zeros = DW - $countones(d);
    @(posedge clk);
    if (del) mq.delete(0);
    if (acc) begin
      mq.push_back(dbi ? ~d : d);
      m_accepted++;
    end
    if (acc && zeros > DBI_THRESHOLD) m_err = 1'b1;
    else if (c)                       m_err = 1'b0;
    if (c)                                   m_cnt = 0;
    else if (acc && dbi && m_cnt < CNT_MAX)  m_cnt++;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [DW-1:0] ed,
                             input logic er, input logic ee, input logic [CW-1:0] ec);
    logic ok;
    ok = (out_valid === ev) && (!ev || out_data === ed) && (in_ready === er) &&
         (err === ee) && (inv_cnt === ec);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: got valid=%0b data=%h ready=%0b err=%0b cnt=%0d, expected valid=%0b data=%h ready=%0b err=%0b cnt=%0d",
               name, out_valid, out_data, in_ready, err, inv_cnt, ev, ed, er, ee, ec);
    end
  endtask

  task automatic checkModel(input string name);
    logic [DW-1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    checkOutput(name, mq.size() > 0, head, mq.size() < 2, m_err, CW'(m_cnt));
  endtask

  initial begin
    int cycles;
    int target;

    compared   = 0;
    mismatched = 0;
    m_accepted = 0;
    resetModel();

    // Decode pass-through (v0..v3) then the rule-violation / clr sequence (v4..v8).
    vecs[0] = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, 4'd1};
    vecs[2] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 4'd2};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd2};
    vecs[4] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 4'd2};
    vecs[5] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 4'd2};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[7] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 4'd0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd0};

    in_valid  = 1'b0;
    in_data   = '0;
    in_dbi    = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
    rst_n     = 1'b0;

    #12;
    checkOutput("reset_state", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    compared++;
    if (out_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_out_data: got %h, expected 00", out_data);
    end
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].dbi, vecs[i].ordy, vecs[i].c);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].er,
                  vecs[i].ee, vecs[i].ec);
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_accept1", 1'b1, 8'h3C, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_full", 1'b1, 8'h3C, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_hold", 1'b1, 8'h3C, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_drain1", 1'b1, 8'h5A, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_drain2", 1'b1, 8'h99, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_empty", 1'b0, 8'h00, 1'b1, 1'b1, 4'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkModel("prefill");
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", 1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
    resetModel();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checkModel($sformatf("post_reset%0d", i));
    end

    $display("[TB] counter saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
      checkModel($sformatf("sat%0d", i));
    end
    compared++;
    if (inv_cnt !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL sat_cnt: got %0d, expected 15", inv_cnt);
    end
    applyStimulus(1'b1, 8'h0F, 1'b1, 1'b1, 1'b1);
    compared++;
    if (inv_cnt !== 4'h0) begin
      mismatched++;
      $display("[TB] FAIL sat_clr: got %0d, expected 0", inv_cnt);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkModel("sat_drain");

    $display("[TB] random stream");
    cycles = 0;
    target = m_accepted + 1000;
    while (m_accepted < target && cycles < 20000) begin
      logic [DW-1:0] rd;
      rd = DW'($urandom());
      applyStimulus($urandom_range(99) < 70, rd, 1'($urandom()),
                    $urandom_range(99) < 70, $urandom_range(99) < 3);
      checkModel("random");
      cycles++;
    end
    compared++;
    if (m_accepted < target) begin
      mismatched++;
      $display("[TB] FAIL random_budget: accepted %0d words, required %0d", m_accepted, target);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checkModel("random_drain");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
